atm_lut_engine: RTL and testbench



---
 rtl/atm_lut_engine.sv | 164 ++++++++++++++++
 tb/tb_atm_lut_engine.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_lut_engine.sv
// atm_lut_engine: multi-channel pipelined VPI lookup table.
// One config write port, NumCh lookup channels sharing one read port through a
// round-robin arbiter, per-entry valid bits and a hardware clear walk.
// Optional feature: define LUT_WR_FWD_EN for write-first forwarding when a
// lookup and a config write hit the same address in the same cycle; without
// it the lookup sees the pre-write contents (read-first).
module atm_lut_engine #(
    parameter int Asize  = 8,
    parameter int dWidth = 16,
    parameter int NumCh  = 4,
    localparam int Arange = 1 << Asize,
    localparam int ChW    = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr_en,
    input  logic [Asize-1:0]       cfg_addr,
    input  logic [dWidth-1:0]      cfg_data,
    input  logic                   cfg_clear,
    output logic                   busy,
    input  logic [NumCh-1:0]       req_valid,
    input  logic [NumCh*Asize-1:0] req_addr,
    output logic [NumCh-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ChW-1:0]         rsp_ch,
    output logic                   rsp_hit,
    output logic [dWidth-1:0]      rsp_data
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            state;
    logic [Asize-1:0]  ptr;
    logic [ChW-1:0]    rr;

    logic [dWidth-1:0] mem [Arange];
    logic [Arange-1:0] vld;

    // Arbiter results
    logic [NumCh-1:0]  grant;
    logic              found;
    logic [ChW-1:0]    gidx;
    logic [ChW-1:0]    cand;
    logic [Asize-1:0]  sel_addr;
    logic [Asize-1:0]  addr_arr [NumCh];

    // Stage-1 registers
    logic              s1_valid;
    logic [ChW-1:0]    s1_ch;
    logic              s1_hit;
    logic [dWidth-1:0] s1_data;

    for (genvar g = 0; g < NumCh; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*Asize +: Asize];
    end

    assign busy      = (state == ST_CLEAR);
    assign req_ready = grant;
    assign sel_addr  = addr_arr[gidx];

`ifdef LUT_WR_FWD_EN
    logic fwd;
    assign fwd = cfg_wr_en && (cfg_addr == sel_addr);
`endif

    // Round-robin arbiter: first requester searching upward from rr+1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        if (state == ST_RUN) begin
            for (int k = 1; k <= NumCh; k++) begin
                cand = ChW'((int'(rr) + k) % NumCh);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
            if (found) begin
                grant[gidx] = 1'b1;
            end
        end
    end

    // Entry storage: config write port and stage-1 data read.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset so it can map onto a plain RAM; validity lives in vld.
        if (!rst && state == ST_RUN && cfg_wr_en) begin
            mem[cfg_addr] <= cfg_data;
        end
        if (found) begin
`ifdef LUT_WR_FWD_EN
            s1_data <= fwd ? cfg_data : mem[sel_addr];
`else
            s1_data <= mem[sel_addr];
`endif
        end
    end

    // Control FSM: clear walk, valid bits, rr pointer and stage-1 tags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
        if (rst) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rr       <= ChW'(NumCh - 1);
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_hit   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    vld[ptr] <= 1'b0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == Asize'(Arange - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cfg_wr_en) begin
                        vld[cfg_addr] <= 1'b1;
                    end
                    if (cfg_clear) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase

            if (found) begin
                rr <= gidx;
            end
            s1_valid <= found;
            s1_ch    <= gidx;
`ifdef LUT_WR_FWD_EN
            s1_hit   <= fwd ? 1'b1 : vld[sel_addr];
`else
            s1_hit   <= vld[sel_addr];
`endif
        end
    end

    // Stage 2: registered response, data forced to zero on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s1_valid;
            rsp_ch    <= s1_ch;
            rsp_hit   <= s1_valid && s1_hit;
            rsp_data  <= (s1_valid && s1_hit) ? s1_data : '0;
        end
    end

endmodule

// File: tb/tb_atm_lut_engine.sv
// Testbench for atm_lut_engine (default parameters: 8-bit address, 16-bit
// data, 4 channels). Table-driven directed lookups, hand-written corner
// sequences and a randomized phase checked against a behavioural model.
module tb_atm_lut_engine;

    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int NCH    = 4;
    localparam int ARANGE = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_wr_en;
    logic [AW-1:0]   cfg_addr;
    logic [DW-1:0]   cfg_data;
    logic            cfg_clear;
    logic            busy;
    logic [NCH-1:0]  req_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]  req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_ch;
    logic            rsp_hit;
    logic [DW-1:0]   rsp_data;

    always #5 clk = ~clk;

    atm_lut_engine #(.Asize(AW), .dWidth(DW), .NumCh(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_clear (cfg_clear),
        .busy      (busy),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_hit   (rsp_hit),
        .rsp_data  (rsp_data)
    );

    // Drive values applied on the next step
    logic          drv_rst = 1'b1;
    logic          drv_wr_en = 1'b0;
    logic [AW-1:0] drv_wr_addr = '0;
    logic [DW-1:0] drv_wr_data = '0;
    logic          drv_clear = 1'b0;
    logic          drv_rv [NCH];
    logic [AW-1:0] drv_addr [NCH];

    // Observations from the last step
    logic           got_valid, got_hit, got_busy;
    logic [1:0]     got_ch;
    logic [DW-1:0]  got_data;
    logic [NCH-1:0] got_ready;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_grant = -1;

    // Behavioural model: table contents, valid flags, clear countdown, rr index
    logic [DW-1:0] m_mem [ARANGE];
    logic          m_vld [ARANGE];
    int            m_clear_left = ARANGE;
    int            m_rr = NCH - 1;

    typedef struct {
        int            due;
        int            ch;
        logic          hit;
        logic [DW-1:0] data;
    } exp_rsp_t;
    exp_rsp_t q[$];

    typedef struct {
        int cyc;
        int ch;
    } rsp_rec_t;
    rsp_rec_t rsp_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply inputs at negedge, observe, compare with model, advance model.
    task automatic step();
        int            g;
        logic [NCH-1:0] eg;
        logic          ev;
        logic [AW-1:0] a;
        logic          h;
        logic [DW-1:0] d;
        @(negedge clk);
        rst       = drv_rst;
        cfg_wr_en = drv_wr_en;
        cfg_addr  = drv_wr_addr;
        cfg_data  = drv_wr_data;
        cfg_clear = drv_clear;
        req_valid = {drv_rv[3], drv_rv[2], drv_rv[1], drv_rv[0]};
        req_addr  = {drv_addr[3], drv_addr[2], drv_addr[1], drv_addr[0]};
        #1;
        got_valid = rsp_valid;
        got_hit   = rsp_hit;
        got_ch    = rsp_ch;
        got_data  = rsp_data;
        got_busy  = busy;
        got_ready = req_ready;
        if (rsp_valid) rsp_log.push_back('{cyc, int'(rsp_ch)});

        g  = -1;
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (!drv_rst) begin
            check("busy", busy, m_clear_left > 0);
            check("rsp_valid", rsp_valid, ev);
            if (ev && rsp_valid) begin
                check("rsp_ch", rsp_ch, q[0].ch);
                check("rsp_hit", rsp_hit, q[0].hit);
                check("rsp_data", rsp_data, q[0].data);
            end
            if (m_clear_left == 0) begin
                for (int k = 1; k <= NCH; k++) begin
                    if (g < 0 && drv_rv[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
                end
            end
            eg = '0;
            if (g >= 0) eg[g[1:0]] = 1'b1;
            check("req_ready", req_ready, eg);
        end
        if (ev) void'(q.pop_front());

        if (drv_rst) begin
            q.delete();
            m_rr = NCH - 1;
            m_clear_left = ARANGE;
            for (int i = 0; i < ARANGE; i++) m_vld[i] = 1'b0;
        end else begin
            if (g >= 0) begin
                a = drv_addr[g];
                h = m_vld[a];
                d = m_mem[a];
`ifdef LUT_WR_FWD_EN
                if (drv_wr_en && drv_wr_addr == a) begin
                    h = 1'b1;
                    d = drv_wr_data;
                end
`endif
                q.push_back('{cyc + 2, g, h, h ? d : '0});
                m_rr = g;
            end
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else begin
                if (drv_wr_en) begin
                    m_mem[drv_wr_addr] = drv_wr_data;
                    m_vld[drv_wr_addr] = 1'b1;
                end
                if (drv_clear) begin
                    m_clear_left = ARANGE;
                    for (int i = 0; i < ARANGE; i++) m_vld[i] = 1'b0;
                end
            end
        end
        last_grant = g;
        cyc++;
    endtask

    // Single lookup on an otherwise idle engine; checks immediate grant and two-cycle latency.
    task automatic lookup_one(input int ch, input logic [AW-1:0] addr,
                              input logic ehit, input logic [DW-1:0] edata);
        drv_rv[ch] = 1'b1;
        drv_addr[ch] = addr;
        step();
        check("lk_grant", got_ready[ch[1:0]], 1'b1);
        drv_rv[ch] = 1'b0;
        step();
        check("lk_early", got_valid, 1'b0);
        step();
        check("lk_valid", got_valid, 1'b1);
        check("lk_ch", got_ch, ch);
        check("lk_hit", got_hit, ehit);
        check("lk_data", got_data, edata);
    endtask

    task automatic write_one(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        drv_wr_en = 1'b1;
        drv_wr_addr = addr;
        drv_wr_data = data;
        step();
        drv_wr_en = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        int            ch;
        logic [AW-1:0] ra;
        logic          ehit;
        logic [DW-1:0] edata;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   prev;
        int   gi;
        int   gorder[$];

        for (int c = 0; c < NCH; c++) begin
            drv_rv[c] = 1'b0;
            drv_addr[c] = '0;
        end
        for (int i = 0; i < ARANGE; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end

        vecs[0] = '{1'b1, 8'h12, 16'hBEEF, 2, 8'h12, 1'b1, 16'hBEEF};
        vecs[1] = '{1'b1, 8'h20, 16'h0001, 1, 8'h20, 1'b1, 16'h0001};
        vecs[2] = '{1'b0, 8'h00, 16'h0000, 3, 8'h21, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 8'h12, 16'hCAFE, 0, 8'h12, 1'b1, 16'hCAFE};
        vecs[4] = '{1'b1, 8'hFF, 16'h8000, 3, 8'hFF, 1'b1, 16'h8000};
        vecs[5] = '{1'b1, 8'h00, 16'h7FFF, 1, 8'h00, 1'b1, 16'h7FFF};

        // Reset with a ch0 lookup of 0x05 already pending
        drv_rst = 1'b1;
        drv_rv[0] = 1'b1;
        drv_addr[0] = 8'h05;
        repeat (3) step();
        check("rst_busy", got_busy, 1'b1);
        check("rst_ready", got_ready, 4'h0);
        check("rst_rsp_valid", got_valid, 1'b0);
        check("rst_rsp_ch", got_ch, 2'd0);
        check("rst_rsp_hit", got_hit, 1'b0);
        check("rst_rsp_data", got_data, 16'h0);

        // Post-reset walk length; first grant in the cycle after busy falls
        drv_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!got_busy) break;
            n++;
        end
        check("walk_len", n, ARANGE);
        check("first_grant", got_ready, 4'h1);
        drv_rv[0] = 1'b0;
        step();
        step();
        check("miss_valid", got_valid, 1'b1);
        check("miss_hit", got_hit, 1'b0);
        check("miss_data", got_data, 16'h0);

        // Table-driven write-then-lookup vectors
        foreach (vecs[i]) begin
            if (vecs[i].wr) write_one(vecs[i].wa, vecs[i].wd);
            lookup_one(vecs[i].ch, vecs[i].ra, vecs[i].ehit, vecs[i].edata);
        end

        // Same-cycle write and lookup of a previously invalid address
        drv_wr_en = 1'b1;
        drv_wr_addr = 8'h40;
        drv_wr_data = 16'h1234;
        drv_rv[0] = 1'b1;
        drv_addr[0] = 8'h40;
        step();
        check("same_grant", got_ready, 4'h1);
        drv_wr_en = 1'b0;
        drv_rv[0] = 1'b0;
        step();
        step();
        check("same_valid", got_valid, 1'b1);
`ifdef LUT_WR_FWD_EN
        check("same_hit", got_hit, 1'b1);
        check("same_data", got_data, 16'h1234);
`else
        check("same_hit", got_hit, 1'b0);
        check("same_data", got_data, 16'h0);
`endif
        step();

        // All channels requesting: grants rotate, responses back-to-back in grant order
        rsp_log.delete();
        for (int c = 0; c < NCH; c++) begin
            drv_rv[c] = 1'b1;
            drv_addr[c] = 8'h12;
        end
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_onehot", $countones(got_ready), 1);
            gi = 0;
            for (int c = 0; c < NCH; c++) if (got_ready[c]) gi = c;
            if (prev >= 0) check("rr_order", gi, (prev + 1) % NCH);
            prev = gi;
            gorder.push_back(gi);
        end
        for (int c = 0; c < NCH; c++) drv_rv[c] = 1'b0;
        step();
        step();
        check("rr_rsp_count", rsp_log.size(), 8);
        if (rsp_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("rr_rsp_ch", rsp_log[i].ch, gorder[i]);
                check("rr_rsp_cyc", rsp_log[i].cyc - rsp_log[0].cyc, i);
            end
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!drv_rv[c] && $urandom_range(0, 1) == 1) begin
                    drv_rv[c] = 1'b1;
                    drv_addr[c] = AW'($urandom_range(0, 31));
                end
            end
            drv_wr_en = ($urandom_range(0, 2) == 0);
            drv_wr_addr = AW'($urandom_range(0, 31));
            drv_wr_data = DW'($urandom);
            drv_clear = ($urandom_range(0, 399) == 0);
            step();
            if (last_grant >= 0) drv_rv[last_grant] = 1'b0;
        end
        drv_wr_en = 1'b0;
        drv_clear = 1'b0;
        for (int c = 0; c < NCH; c++) drv_rv[c] = 1'b0;
        n = 0;
        while ((m_clear_left > 0 || q.size() > 0) && n < 400) begin
            step();
            n++;
        end
        check("drain", (m_clear_left == 0) && (q.size() == 0), 1'b1);

        // Software clear: walk length, writes ignored during the walk, entries miss afterwards
        write_one(8'h01, 16'h1111);
        write_one(8'hFF, 16'h2222);
        lookup_one(1, 8'h01, 1'b1, 16'h1111);
        drv_clear = 1'b1;
        step();
        drv_clear = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            drv_wr_en = (k < ARANGE);
            drv_wr_addr = 8'h01;
            drv_wr_data = 16'hAAAA;
            step();
            if (!got_busy) break;
            n++;
        end
        drv_wr_en = 1'b0;
        check("clear_len", n, ARANGE);
        lookup_one(2, 8'h01, 1'b0, 16'h0);
        lookup_one(3, 8'hFF, 1'b0, 16'h0);

        // Reset one cycle after a grant discards the in-flight lookup
        write_one(8'h12, 16'h5A5A);
        drv_rv[1] = 1'b1;
        drv_addr[1] = 8'h12;
        step();
        check("mid_grant", got_ready, 4'h2);
        drv_rv[1] = 1'b0;
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        step();
        check("mid_busy", got_busy, 1'b1);
        check("mid_no_rsp", got_valid, 1'b0);
        step();
        check("mid_no_rsp2", got_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
